data_mem_responder: RTL
=======================

# data_mem_responder

Data-memory responder for the core's MEM stage: the target side of the stage's `ce` / `data_mem_rw` / `addr` / byte-valid request and `data_mem_ready` completion handshake. Holds a word-addressed 64-bit RAM with byte-lane write enables. Returns `data_mem_ready` after a fixed, parameterised access latency. Models the multi-cycle memory that the MEM stage stalls on.

## Interface
- `DEPTH_WORDS`, 512: number of 64-bit words; power of two, 2..65536.
- `LATENCY`, 4: cycles from request sample to `data_mem_ready`; range 2..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low (0 = reset).
- `ce`  in  1  request valid; held high by the requester until it sees `data_mem_ready`.
- `data_mem_rw`  in  1  0 = read, 1 = write.
- `addr`  in  64  byte address; `addr[2:0]` ignored.
- `wdata`  in  64  write data.
- `mem_data_byte_valid`  in  8  write byte enables; bit i covers `wdata[8i+7:8i]`.
- `rdata`  out  64  read data, registered.
- `data_mem_ready`  out  1  completion pulse, registered.
- `err`  out  1  access error; present only with `DATA_MEM_ERR_EN`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If `ce`=1 at an edge, latch `data_mem_rw`, `addr`, `wdata` and `mem_data_byte_valid`.
  - Load the latency counter and go to BUSY.
  - Inputs after the latch edge are ignored until the FSM returns to IDLE.
- BUSY:
  - Counter decrements each cycle.
  - On the final edge the access is performed, `data_mem_ready` is set to 1 and the FSM goes to DONE.
- DONE:
  - `data_mem_ready` is high for exactly this one cycle.
  - `ce` is ignored here, because it is still the completed request.
  - Next edge: `data_mem_ready` goes to 0 and the FSM goes to IDLE.
- Word index = `addr[log2(DEPTH_WORDS)+2:3]`.
  - In range: all of `addr[63:log2(DEPTH_WORDS)+3]` are zero.
  - Out of range: a read returns 0 and a write is dropped.
- Write: byte i of the word is replaced by byte i of `wdata` only where `mem_data_byte_valid[i]`=1. `mem_data_byte_valid`=0x00 is a legal no-op write. `rdata` is unchanged by writes.
- Read: `rdata` loads the full 64-bit word and ignores the byte enables; the requester does lane extraction. `rdata` holds until the next read completes.
- RAM contents are not reset.
- Reset values: state IDLE, `data_mem_ready`=0, `rdata`=0, `err`=0, counter 0.
- Reset mid-operation aborts the request. No write is committed unless the commit edge occurred before reset asserted.

## Timing
- Request sampled at edge E (FSM in IDLE, `ce`=1).
- `data_mem_ready`=1 exactly during the cycle following edge E+LATENCY−1, i.e. LATENCY cycles after the cycle in which `ce` was sampled.
- The write commits on that same edge, and `rdata` is valid in that same cycle.
- Throughput: the next request is sampled at earliest at the edge ending the cycle after DONE. Back-to-back spacing is LATENCY+1 cycles.
- No combinational path from any input to any output.

## Configuration
- `DATA_MEM_ERR_EN` defined:
  - Port `err` exists.
  - `err`=1 in the DONE cycle if the access was out of range, or was a write with `mem_data_byte_valid`=0x00.
  - `err`=0 at all other times.
- `DATA_MEM_ERR_EN` undefined:
  - No `err` port and no error logic.
  - Out-of-range accesses behave identically (read 0, write dropped) but are silent.

## Test plan
- Full write and readback:
  - Stimulus: after reset, write `wdata`=0x1122334455667788 to `addr`=0x10 with enables 0xFF, `ce` held until ready.
  - Required: `data_mem_ready` is high only in the 4th cycle after sampling, for exactly one cycle.
  - Follow-up: a read of 0x10 gives `rdata`=0x1122334455667788 in its ready cycle.
- Byte merge:
  - Stimulus: over that word, write `wdata`=0xAA with enables 0x01, then write `wdata`=0xBB00000000000000 with enables 0x80.
  - Required: a read of 0x10 returns 0xBB223344556677AA.
  - Also: a read of 0x17 returns the same word, since `addr[2:0]` is ignored.
- Held `ce` and back-to-back:
  - Stimulus: keep `ce`=1 through DONE, then present a new read immediately.
  - Required: exactly one access per request.
  - Required: the second `data_mem_ready` arrives 5 cycles after the first.
- Reset mid-write:
  - Stimulus: drive `rst`=0 two cycles after sampling a write of 0xFFFF… to 0x10.
  - Required: `data_mem_ready` stays 0 and `rdata`=0.
  - Required: after release, a read of 0x10 returns the old word.
- Out of range:
  - Stimulus: with DEPTH_WORDS=512, read `addr`=0x1000, then write 0x1234 to 0x1000.
  - Required: both complete with normal latency and the read returns 0.
  - With `DATA_MEM_ERR_EN`: `err`=1 in both ready cycles.
  - With `DATA_MEM_ERR_EN`: a write to 0x8 with enables 0x00 also gives `err`=1.
- Minimum latency:
  - Stimulus: LATENCY=2, repeat the full write and readback scenario.
  - Required: ready in the 2nd cycle after sampling, and identical data results.

Source files
------------

// File: rtl/data_mem_if.sv
// Request/completion bundle between the MEM stage (master) and the data
// memory (slave). The err wire exists only when DATA_MEM_ERR_EN is defined.
interface data_mem_if;
  logic        ce;
  logic        data_mem_rw;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  mem_data_byte_valid;
  logic [63:0] rdata;
  logic        data_mem_ready;
`ifdef DATA_MEM_ERR_EN
  logic        err;

  modport master (
    output ce, data_mem_rw, addr, wdata, mem_data_byte_valid,
    input  rdata, data_mem_ready, err
  );

  modport slave (
    input  ce, data_mem_rw, addr, wdata, mem_data_byte_valid,
    output rdata, data_mem_ready, err
  );
`else
  modport master (
    output ce, data_mem_rw, addr, wdata, mem_data_byte_valid,
    input  rdata, data_mem_ready
  );

  modport slave (
    input  ce, data_mem_rw, addr, wdata, mem_data_byte_valid,
    output rdata, data_mem_ready
  );
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory behind the MEM stage handshake.
// Word-addressed 64-bit RAM split into eight byte lanes so byte enables map
// straight onto per-lane write enables. A request is latched in IDLE, waits
// LATENCY-1 cycles in BUSY, is performed on the last BUSY edge and reported
// with a one-cycle data_mem_ready pulse in DONE.
// Optional feature macro: DATA_MEM_ERR_EN (adds the err output and its logic).
module data_mem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 4
) (
  input  logic       clk,
  input  logic       rst,       // active-low, asynchronous assert
  data_mem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          in_range_q, in_range_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    be_q, be_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
`ifdef DATA_MEM_ERR_EN
  logic          err_q, err_d;
`endif

  logic [AW-1:0] addr_idx;
  logic          addr_in_range;
  logic          commit;
  logic [AW-1:0] ram_rd_idx;
  logic [63:0]   ram_rd;
  logic          unused_addr_bits;

  // Decode the incoming byte address into a word index and a range flag.
  assign addr_idx         = bus.addr[AW+2:3];
  assign addr_in_range    = (bus.addr[63:AW+3] == '0);
  assign unused_addr_bits = ^bus.addr[2:0];

  // The access happens on the last BUSY edge.
  assign commit = (state_q == BUSY) && (cnt_q == 4'd1);

  // While idle the RAM is pre-read at the incoming address so that even the
  // shortest latency has the word ready one edge before the commit edge.
  assign ram_rd_idx = (state_q == IDLE) ? addr_idx : idx_q;

  // Byte-lane RAMs: registered read every cycle, write only on a committed,
  // in-range, enabled lane. No reset so the arrays map onto block RAM.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] lane_rd_q;

    // Lane write on commit and registered read of the current index.
    always_ff @(posedge clk) begin
      if (commit && rw_q && in_range_q && be_q[gi]) begin
        lane_mem[idx_q] <= wdata_q[8*gi +: 8];
      end
      lane_rd_q <= lane_mem[ram_rd_idx];
    end

    assign ram_rd[8*gi +: 8] = lane_rd_q;
  end

  // Next-state logic for the IDLE -> BUSY -> DONE request sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
`ifdef DATA_MEM_ERR_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.ce) begin
          rw_d       = bus.data_mem_rw;
          idx_d      = addr_idx;
          in_range_d = addr_in_range;
          wdata_d    = bus.wdata;
          be_d       = bus.mem_data_byte_valid;
          cnt_d      = 4'(LATENCY - 1);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          ready_d = 1'b1;
          // Reads return the whole word; out-of-range reads return zero.
          if (!rw_q) begin
            rdata_d = in_range_q ? ram_rd : 64'd0;
          end
`ifdef DATA_MEM_ERR_EN
          err_d = !in_range_q || (rw_q && (be_q == 8'h00));
`endif
        end
      end
      DONE: begin
        // ce is still the completed request here, so it is not sampled.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rw_q       <= 1'b0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      wdata_q    <= 64'd0;
      be_q       <= 8'h00;
      rdata_q    <= 64'd0;
      ready_q    <= 1'b0;
`ifdef DATA_MEM_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
`ifdef DATA_MEM_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  assign bus.rdata          = rdata_q;
  assign bus.data_mem_ready = ready_q;
`ifdef DATA_MEM_ERR_EN
  assign bus.err            = err_q;
`endif

endmodule
